// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: round-robin owner arbitration and tagged read return for the shared single-port S memory
module s_mem_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic [NUM_REQ-1:0]        rd_in,
  input  logic [NUM_REQ-1:0]        wren_in,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_data,
  output logic                      mem_wren,
  input  logic [DATA_W-1:0]         mem_q,
  output logic [DATA_W-1:0]         q_out,
  output logic [NUM_REQ-1:0]        q_valid,
  output logic                      busy
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, rr_q, rr_d, pick;
  logic hit, owned, held, rd_issue;
  logic [READ_LATENCY-1:0] tv_q;
  logic [IW-1:0] ti_q [READ_LATENCY];
  assign owned = state_q == OWNED;
  // a low req while still granted is the release cycle: accesses are gated off
  assign held = owned & req[owner_q];
  assign rd_issue = held & rd_in[owner_q] & ~wren_in[owner_q];
  assign gnt = owned ? NUM_REQ'(1) << owner_q : '0;
  assign busy = owned;
  assign mem_address = owned ? addr_in[int'(owner_q)*ADDR_W +: ADDR_W] : '0;
  assign mem_data = owned ? data_in[int'(owner_q)*DATA_W +: DATA_W] : '0;
  assign mem_wren = held & wren_in[owner_q];
  assign q_out = mem_q;
  assign q_valid = tv_q[READ_LATENCY-1] ? NUM_REQ'(1) << ti_q[READ_LATENCY-1] : '0;
  // descending scan so the requester closest to rr_q wins
  always_comb begin
    hit = 1'b0;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_q) + k) % NUM_REQ]) begin
        hit = 1'b1;
        pick = IW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    if (!held) begin
      state_d = hit ? OWNED : IDLE;
      owner_d = hit ? pick : owner_q;
      rr_d = !hit ? rr_q : (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
    end
  end
  // read tags ride alongside the memory pipeline and outlive the issuing grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tv_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) ti_q[k] <= '0;
    end else begin
      tv_q[0] <= rd_issue;
      ti_q[0] <= owner_q;
      for (int k = 1; k < READ_LATENCY; k++) begin
        tv_q[k] <= tv_q[k-1];
        ti_q[k] <= ti_q[k-1];
      end
    end
  end
endmodule

// File: tb/tb_s_mem_arbiter.sv
// tb_s_mem_arbiter: scoreboard bench driving READ_LATENCY=1 and =3 arbiters with identical stimulus
module tb_s_mem_arbiter;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0, rd = '0, wr = '0;
  logic [N*8-1:0] addr = '0, data = '0;
  logic [N-1:0] gnt [2], qv [2];
  logic [7:0] ma [2], md [2], mq [2], qo [2];
  logic mw [2], bz [2];
  int cyc = 0, n_chk = 0, n_fail = 0;
  int m_owner = -1, m_rr = 0, m_cur = -1;
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  typedef struct {int idx; logic [7:0] d; int due;} rd_t;
  typedef struct {logic [N-1:0] g; logic w; logic [7:0] a; logic [7:0] d;} ex_t;
  rd_t sb0[$], sb1[$];
  ex_t exq[$];
  ex_t mon_e;
  rd_t mon_f;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  s_mem_arbiter #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(8), .READ_LATENCY(1)) u_l1 (
    .clock(clk), .reset(rst), .req(req), .gnt(gnt[0]), .rd_in(rd), .wren_in(wr),
    .addr_in(addr), .data_in(data), .mem_address(ma[0]), .mem_data(md[0]), .mem_wren(mw[0]),
    .mem_q(mq[0]), .q_out(qo[0]), .q_valid(qv[0]), .busy(bz[0]));
  s_mem_arbiter #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(8), .READ_LATENCY(3)) u_l3 (
    .clock(clk), .reset(rst), .req(req), .gnt(gnt[1]), .rd_in(rd), .wren_in(wr),
    .addr_in(addr), .data_in(data), .mem_address(ma[1]), .mem_data(md[1]), .mem_wren(mw[1]),
    .mem_q(mq[1]), .q_out(qo[1]), .q_valid(qv[1]), .busy(bz[1]));
  for (genvar g = 0; g < 2; g++) begin : g_mem
    localparam int RL = g ? 3 : 1;
    logic [7:0] smem [256] = '{default: 8'h00};
    logic [7:0] pipe [RL];
    always @(posedge clk) begin
      if (mw[g]) smem[ma[g]] <= md[g];
      pipe[0] <= smem[ma[g]];
      for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
    end
    assign mq[g] = pipe[RL-1];
  end
  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (lat%0d) cycle %0d: got %0h expected %0h", nm, g ? 3 : 1, cyc, act, exp);
    end
  endtask
  // reference: one owner at a time, round-robin after the last grantee, reads return ref_mem at issue
  task automatic model();
    ex_t e;
    logic [7:0] a, d;
    int o;
    #1;
    e = '{default: 0};
    m_cur = rst ? -1 : m_owner;
    if (rst) begin
      m_owner = -1;
      m_rr = 0;
      sb0.delete();
      sb1.delete();
    end else begin
      o = m_owner;
      if (o >= 0) begin
        a = addr[o*8 +: 8];
        d = data[o*8 +: 8];
        e.g = N'(1) << o;
        e.a = a;
        e.d = d;
        e.w = req[o] & wr[o];
        if (req[o] && rd[o] && !wr[o]) begin
          sb0.push_back('{o, ref_mem[a], cyc + 1});
          sb1.push_back('{o, ref_mem[a], cyc + 3});
        end
        if (e.w) ref_mem[a] = d;
        if (!req[o]) m_owner = -1;
      end
      if (m_owner < 0)
        for (int k = 0; k < N; k++)
          if (req[(m_rr + k) % N]) begin
            m_owner = (m_rr + k) % N;
            m_rr = (m_owner + 1) % N;
            break;
          end
    end
    exq.push_back(e);
  endtask
  task automatic tick();
    model();
    @(negedge clk);
  endtask
  task automatic set(input int i, input logic [7:0] a, input logic [7:0] d);
    addr[i*8 +: 8] = a;
    data[i*8 +: 8] = d;
  endtask
  task automatic rand_bus();
    rd = N'($urandom);
    wr = N'($urandom) & N'($urandom);
    for (int i = 0; i < N; i++) set(i, 8'h50 + 8'($urandom_range(7)), 8'($urandom));
  endtask
  // each requester holds until it has owned for h cycles, then drops req
  task automatic hold_run(input logic [N-1:0] m, input int h);
    int held [N];
    logic [N-1:0] p;
    p = m;
    foreach (held[i]) held[i] = 0;
    for (int t = 0; t < 60 && (p != 0 || m_owner >= 0); t++) begin
      req = p;
      rand_bus();
      tick();
      if (m_cur >= 0 && p[m_cur]) begin
        held[m_cur]++;
        if (held[m_cur] == h) p[m_cur] = 1'b0;
      end
    end
    req = '0; rd = '0; wr = '0;
  endtask
  always @(negedge clk) begin
    #2;
    if (exq.size() > 0) begin
      mon_e = exq.pop_front();
      for (int g = 0; g < 2; g++) begin
        chk("gnt", g, 32'(gnt[g]), 32'(mon_e.g));
        chk("busy", g, 32'(bz[g]), 32'(|mon_e.g));
        chk("mem_wren", g, 32'(mw[g]), 32'(mon_e.w));
        chk("mem_address", g, 32'(ma[g]), 32'(mon_e.a));
        chk("mem_data", g, 32'(md[g]), 32'(mon_e.d));
        if (qv[g] != '0) begin
          if ((g ? sb1.size() : sb0.size()) == 0) chk("q_valid_spurious", g, 32'(qv[g]), 32'd0);
          else begin
            if (g) mon_f = sb1.pop_front();
            else mon_f = sb0.pop_front();
            chk("q_valid_tag", g, 32'(qv[g]), 32'(N'(1) << mon_f.idx));
            chk("q_out", g, 32'(qo[g]), 32'(mon_f.d));
            chk("q_valid_time", g, cyc, mon_f.due);
          end
        end else if ((g ? sb1.size() : sb0.size()) > 0) begin
          mon_f = g ? sb1[0] : sb0[0];
          if (mon_f.due <= cyc) begin
            chk("q_valid_missing", g, 32'(qv[g]), 32'(N'(1) << mon_f.idx));
            if (g) void'(sb1.pop_front());
            else void'(sb0.pop_front());
          end
        end
      end
    end
  end
  initial begin
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    req = 3'b001; tick();
    wr = 3'b001; set(0, 8'h05, 8'hA5); tick();
    wr = '0; rd = 3'b001; set(0, 8'h05, 8'h00); tick();
    rd = '0; tick();
    req = '0; tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    hold_run(3'b111, 4);
    hold_run(3'b101, 4);
    req = 3'b010; set(1, 8'h11, 8'h00); tick();
    wr = 3'b100; set(2, 8'h10, 8'hFF); tick(); tick();
    wr = '0; rd = 3'b010; set(1, 8'h10, 8'h00); tick();
    rd = '0; req = '0; tick(); tick(); tick();
    req = 3'b001; tick();
    wr = 3'b001; set(0, 8'h20, 8'h77); req = 3'b011; tick();
    wr = '0; rd = 3'b001; set(0, 8'h20, 8'h00); tick();
    rd = '0; req = 3'b010; set(1, 8'h21, 8'h00); tick();
    repeat (4) tick();
    req = '0; repeat (4) tick();
    req = 3'b001; tick();
    rd = 3'b001; wr = 3'b001; set(0, 8'h30, 8'h3C); tick();
    wr = '0; tick();
    rd = '0; req = '0; repeat (4) tick();
    req = 3'b010; tick();
    rd = 3'b010; set(1, 8'h41, 8'h00); tick();
    rd = '0; wr = 3'b010; set(1, 8'h40, 8'h99); rst = 1'b1; tick();
    rst = 1'b0; wr = '0; req = '0; tick();
    req = 3'b101; tick(); tick();
    req = '0; tick(); tick();
    req = 3'b001; tick();
    rd = 3'b001; set(0, 8'h40, 8'h00); tick();
    rd = '0; req = '0; repeat (4) tick();
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
      rand_bus();
      rst = (t == 400);
      tick();
    end
    rst = 1'b0; req = '0; rd = '0; wr = '0;
    repeat (6) tick();
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/s_mem_arbiter.md
Name: s_mem_arbiter

Overview:
Round-robin arbiter and access sequencer for the shared 256x8 S memory. It replaces ad-hoc OR-ing of task FSM address/data/wren buses. Task FSMs (init, key-schedule, decrypt, …) request ownership, hold it for multi-cycle read-modify-write sequences, and receive tagged read data. Sits between the task FSMs and the single-port s_memory instance in the top level.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
READ_LATENCY, 1, clock edges from address presented to mem_q valid (1..3)

Ports:
clock  in  1  system clock (CLOCK_50 domain)
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester ownership request, level, held for whole transaction
gnt  out  NUM_REQ  one-hot (or zero) ownership grant, registered
rd_in  in  NUM_REQ  per-requester read strobe, honoured only while owner
wren_in  in  NUM_REQ  per-requester write enable, honoured only while owner
addr_in  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
data_in  in  NUM_REQ*DATA_W  packed write data, same packing
mem_address  out  ADDR_W  to s_memory address
mem_data  out  DATA_W  to s_memory data
mem_wren  out  1  to s_memory wren
mem_q  in  DATA_W  from s_memory q
q_out  out  DATA_W  read data, broadcast to all requesters (= mem_q)
q_valid  out  NUM_REQ  one-hot, requester i's read data valid on q_out this cycle
busy  out  1  high while any grant is held

Behaviour:
- States: IDLE (no owner), OWNED (owner index valid). rr_ptr = index of highest-priority requester.
- Reset (async, any time incl. mid-transaction): state IDLE, gnt=0, busy=0, rr_ptr=0, read tag pipeline cleared, q_valid=0. mem_address/mem_data/mem_wren are 0 whenever no owner.
- IDLE: on clock edge with any req high, grant first requester with req high scanning rr_ptr, rr_ptr+1, … mod NUM_REQ; gnt[i] high from the next cycle (1-cycle grant latency); state OWNED; rr_ptr <= (i+1) mod NUM_REQ.
- OWNED, owner i: mux passes addr_in[i], data_in[i] combinationally. mem_wren = wren_in[i] & req[i]. Read issued when rd_in[i] & req[i] & ~wren_in[i] (write wins if both high; no read tag).
- Release: edge sampling req[i]=0 with gnt[i]=1 → gnt[i] drops at that edge. If another req is high at that same edge, new grant (round-robin from updated rr_ptr) takes effect at the same edge — zero idle cycles between owners; else IDLE. During the cycle where req[i] low but gnt[i] still high, writes/reads are suppressed (gated by req).
- Grant is non-preemptive: owner keeps gnt while req held, regardless of other requests. No timeout.
- Read data: each issued read pushes tag (valid, owner index) into READ_LATENCY-deep shift register; q_valid[tag] asserts exactly READ_LATENCY cycles after the issue cycle, in step with mem_q. Tags survive ownership change (data returns to original issuer even after release).
- rd_in/wren_in/addr_in from non-owners ignored entirely.
- gnt is never more than one-hot; busy = |gnt.
- Back-to-back reads every cycle by owner supported (full throughput).

Test Plan:
- Reset/idle: assert reset mid-write by requester 1 → gnt=0, mem_wren=0, q_valid=0 same cycle (async); after release rr_ptr=0.
- Single requester: req[0] at t0 → gnt[0]=1 at t1; write addr 8'h05 data 8'hA5 at t1; read 8'h05 at t2 → q_valid[0]=1, q_out=8'hA5 at t3 (READ_LATENCY=1).
- Contention: req[0..2] all rise same edge, rr_ptr=0 → grants in order 0,1,2, each owner releasing after 4 cycles, handoff with no idle cycle; then req[0] and req[2] again → order 2? no: rr_ptr=0 → 0 then 2.
- Non-owner isolation: req[1] owns, requester 2 drives wren_in=1 addr 8'h10 data 8'hFF → memory at 8'h10 unchanged; mem_address tracks addr_in[1] only.
- Read tag across handoff: owner 0 reads 8'h20 on its last cycle, releases, requester 1 granted → q_valid[0] (not [1]) asserts READ_LATENCY cycles later; repeat with READ_LATENCY=3.
- Simultaneous rd_in & wren_in by owner at 8'h30 data 8'h3C → write performed, no q_valid produced; subsequent read returns 8'h3C.
